dap_ap_mux: RTL and testbench

//  Sequences AP transactions issued by the JTAG debug port and shares one DP between NUM_AP access ports.

---
 rtl/dap_ap_mux.sv | 159 +++++++++++++++
 tb/tb_dap_ap_mux.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dap_ap_mux.sv
// dap_ap_mux: shares one debug port between NUM_AP access ports.
// A DP transaction (ap_upd) is decoded by ap_sel and forwarded as a one-hot
// request level that stays up until the addressed AP strobes m_ready.
// Also handles unmapped selects, timeout, abort and a sticky error flag.
module dap_ap_mux #(
    parameter int NUM_AP  = 4,
    parameter int TMO_W   = 8,
    parameter int TMO_CYC = 200
) (
    input  logic                  tck,
    input  logic                  trst,
    input  logic                  ap_upd,
    input  logic [7:0]            ap_sel,
    input  logic [5:0]            ap_addr,
    input  logic [31:0]           ap_wdata,
    input  logic                  ap_rnw,
    input  logic                  ap_abort,
    input  logic                  ap_clrerr,
    output logic                  ap_busy,
    output logic [31:0]           ap_rdata,
    output logic                  ap_slverr,
    output logic [2:0]            ap_ack,
    output logic [NUM_AP-1:0]     m_req,
    output logic [5:0]            m_addr,
    output logic [31:0]           m_wdata,
    output logic                  m_rnw,
    input  logic [NUM_AP-1:0]     m_ready,
    input  logic [NUM_AP*32-1:0]  m_rdata,
    input  logic [NUM_AP-1:0]     m_slverr
);

    localparam int SEL_W = (NUM_AP > 1) ? $clog2(NUM_AP) : 1;
    localparam logic [8:0] NUM_AP_9 = 9'(NUM_AP);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACT  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [SEL_W-1:0]   sel_reg, sel_next;
    logic [5:0]         addr_reg, addr_next;
    logic [31:0]        wdata_reg, wdata_next;
    logic               rnw_reg, rnw_next;
    logic               err_rnw_reg, err_rnw_next;
    logic [31:0]        rdata_reg, rdata_next;
    logic               slverr_reg, slverr_next;
    logic [TMO_W-1:0]   tmo_cnt_reg, tmo_cnt_next;
    logic               slv_set;

    logic [31:0]        ap_rdata_arr [NUM_AP];

    // Per-AP read data slices and request decode. m_req is derived from the
    // asynchronously reset state so it drops the instant trst rises.
    generate
        for (genvar gi = 0; gi < NUM_AP; gi++) begin : g_ap
            assign ap_rdata_arr[gi] = m_rdata[32*gi +: 32];
            assign m_req[gi] = (state_reg == ST_ACT) && (sel_reg == SEL_W'(gi));
        end
    endgenerate

    assign ap_busy   = (state_reg != ST_IDLE);
    assign ap_ack    = ap_busy ? 3'h1 : 3'h2;
    assign ap_rdata  = rdata_reg;
    assign ap_slverr = slverr_reg;
    assign m_addr    = addr_reg;
    assign m_wdata   = wdata_reg;
    assign m_rnw     = rnw_reg;

    // State and datapath registers.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state_reg   <= ST_IDLE;
            sel_reg     <= '0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            rnw_reg     <= 1'b0;
            err_rnw_reg <= 1'b0;
            rdata_reg   <= '0;
            slverr_reg  <= 1'b0;
            tmo_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            sel_reg     <= sel_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            rnw_reg     <= rnw_next;
            err_rnw_reg <= err_rnw_next;
            rdata_reg   <= rdata_next;
            slverr_reg  <= slverr_next;
            tmo_cnt_reg <= tmo_cnt_next;
        end
    end

    // Next-state logic. In ACT the completion sources are prioritised
    // m_ready > abort > timeout; abort leaves ap_rdata alone, timeout zeroes it.
    always_comb begin
        state_next   = state_reg;
        sel_next     = sel_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        rnw_next     = rnw_reg;
        err_rnw_next = err_rnw_reg;
        rdata_next   = rdata_reg;
        tmo_cnt_next = tmo_cnt_reg;
        slv_set      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (ap_upd) begin
                    if ({1'b0, ap_sel} < NUM_AP_9) begin
                        state_next   = ST_ACT;
                        sel_next     = ap_sel[SEL_W-1:0];
                        addr_next    = ap_addr;
                        wdata_next   = ap_wdata;
                        rnw_next     = ap_rnw;
                        tmo_cnt_next = '0;
                    end else begin
                        // Unmapped AP: nothing is requested, m_* keep their values.
                        state_next   = ST_ERR;
                        err_rnw_next = ap_rnw;
                    end
                end
            end
            ST_ACT: begin
                tmo_cnt_next = tmo_cnt_reg + 1'b1;
                if (m_ready[sel_reg]) begin
                    state_next = ST_IDLE;
                    slv_set    = m_slverr[sel_reg];
                    if (rnw_reg)
                        rdata_next = m_slverr[sel_reg] ? 32'h0 : ap_rdata_arr[sel_reg];
                end else if (ap_abort) begin
                    state_next = ST_IDLE;
                    slv_set    = 1'b1;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    state_next = ST_IDLE;
                    slv_set    = 1'b1;
                    if (rnw_reg)
                        rdata_next = 32'h0;
                end
            end
            ST_ERR: begin
                state_next = ST_IDLE;
                slv_set    = 1'b1;
                if (err_rnw_reg)
                    rdata_next = 32'h0;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Sticky error: a new error in the same cycle outranks the clear.
        slverr_next = slv_set ? 1'b1 : (ap_clrerr ? 1'b0 : slverr_reg);
    end

endmodule

// File: tb/tb_dap_ap_mux.sv
// Self-checking bench for dap_ap_mux. Each completed transaction pops its
// expected {rdata, slverr} from a queue filled at issue time.
`timescale 1ns/1ps
module tb_dap_ap_mux;

    localparam int NUM_AP = 4;

    logic                 tck = 1'b0;
    logic                 trst = 1'b1;
    logic                 ap_upd = 1'b0;
    logic [7:0]           ap_sel = '0;
    logic [5:0]           ap_addr = '0;
    logic [31:0]          ap_wdata = '0;
    logic                 ap_rnw = 1'b0;
    logic                 ap_abort = 1'b0;
    logic                 ap_clrerr = 1'b0;
    logic                 ap_busy;
    logic [31:0]          ap_rdata;
    logic                 ap_slverr;
    logic [2:0]           ap_ack;
    logic [NUM_AP-1:0]    m_req;
    logic [5:0]           m_addr;
    logic [31:0]          m_wdata;
    logic                 m_rnw;
    logic [NUM_AP-1:0]    m_ready = '0;
    logic [NUM_AP*32-1:0] m_rdata = '0;
    logic [NUM_AP-1:0]    m_slverr = '0;

    typedef struct {
        logic [31:0] rdata;
        logic        slverr;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail = 0;

    dap_ap_mux #(.NUM_AP(NUM_AP), .TMO_W(8), .TMO_CYC(200)) dut (
        .tck(tck), .trst(trst), .ap_upd(ap_upd), .ap_sel(ap_sel),
        .ap_addr(ap_addr), .ap_wdata(ap_wdata), .ap_rnw(ap_rnw),
        .ap_abort(ap_abort), .ap_clrerr(ap_clrerr), .ap_busy(ap_busy),
        .ap_rdata(ap_rdata), .ap_slverr(ap_slverr), .ap_ack(ap_ack),
        .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_rnw(m_rnw),
        .m_ready(m_ready), .m_rdata(m_rdata), .m_slverr(m_slverr)
    );

    always #5 tck = ~tck;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    // Drive a one-cycle ap_upd; returns in the cycle after the pulse.
    task automatic issue(input logic [7:0] sel, input logic [5:0] addr,
                         input logic [31:0] wdata, input logic rnw);
        ap_upd = 1'b1; ap_sel = sel; ap_addr = addr; ap_wdata = wdata; ap_rnw = rnw;
        tick();
        ap_upd = 1'b0;
        $display("issue sel=%0d addr=%h wdata=%h rnw=%0d", sel, addr, wdata, rnw);
    endtask

    task automatic test_reset();
        trst = 1'b1;
        tick(); tick();
        n_checks++;
        if (ap_busy !== 1'b0 || ap_ack !== 3'h2 || m_req !== 4'b0 ||
            ap_rdata !== 32'h0 || ap_slverr !== 1'b0 || m_addr !== 6'h0 ||
            m_wdata !== 32'h0 || m_rnw !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: busy=%b ack=%h req=%b rdata=%h slverr=%b addr=%h wdata=%h rnw=%b, expected 0/2/0/0/0/0/0/0",
                     ap_busy, ap_ack, m_req, ap_rdata, ap_slverr, m_addr, m_wdata, m_rnw);
        end
        trst = 1'b0;
        tick();
        $display("reset done");
    endtask

    task automatic test_read();
        issue(8'd1, 6'h3, 32'h0, 1'b1);
        exp_q.push_back('{rdata: 32'hCAFE_F00D, slverr: 1'b0});
        n_checks++;
        if (m_addr !== 6'h3 || m_rnw !== 1'b1) begin
            n_fail++;
            $display("FAIL read_regs: addr=%h rnw=%b, expected 03/1", m_addr, m_rnw);
        end
        for (int c = 1; c <= 3; c++) begin
            n_checks++;
            if (m_req !== 4'b0010 || ap_busy !== 1'b1 || ap_ack !== 3'h1) begin
                n_fail++;
                $display("FAIL read_busy c%0d: req=%b busy=%b ack=%h, expected 0010/1/1", c, m_req, ap_busy, ap_ack);
            end
            if (c == 3) begin
                m_ready = 4'b0010;
                m_rdata[32*1 +: 32] = 32'hCAFE_F00D;
            end
            tick();
        end
        m_ready = '0;
        e = exp_q.pop_front();
        n_checks++;
        if (ap_busy !== 1'b0 || ap_ack !== 3'h2 || m_req !== 4'b0 ||
            ap_rdata !== e.rdata || ap_slverr !== e.slverr) begin
            n_fail++;
            $display("FAIL read_done: busy=%b ack=%h req=%b rdata=%h slverr=%b, expected 0/2/0/%h/%b",
                     ap_busy, ap_ack, m_req, ap_rdata, ap_slverr, e.rdata, e.slverr);
        end
        $display("read sel=1 rdata=%h slverr=%b", ap_rdata, ap_slverr);
    endtask

    task automatic test_unmapped();
        issue(8'd9, 6'h5, 32'hDEAD_0000, 1'b0);
        exp_q.push_back('{rdata: 32'hCAFE_F00D, slverr: 1'b1});
        n_checks++;
        if (ap_busy !== 1'b1 || m_req !== 4'b0 || ap_ack !== 3'h1) begin
            n_fail++;
            $display("FAIL unmapped_busy: busy=%b req=%b ack=%h, expected 1/0000/1", ap_busy, m_req, ap_ack);
        end
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (ap_busy !== 1'b0 || ap_rdata !== e.rdata || ap_slverr !== e.slverr || m_addr !== 6'h3) begin
            n_fail++;
            $display("FAIL unmapped_done: busy=%b rdata=%h slverr=%b addr=%h, expected 0/%h/%b/03",
                     ap_busy, ap_rdata, ap_slverr, m_addr, e.rdata, e.slverr);
        end
        ap_clrerr = 1'b1;
        tick();
        ap_clrerr = 1'b0;
        n_checks++;
        if (ap_slverr !== 1'b0) begin
            n_fail++;
            $display("FAIL clrerr: slverr=%b, expected 0", ap_slverr);
        end
        $display("unmapped sel=9 completed, error cleared");
    endtask

    task automatic test_timeout();
        int n;
        issue(8'd2, 6'h7, 32'h0, 1'b1);
        exp_q.push_back('{rdata: 32'h0, slverr: 1'b1});
        n = 0;
        while (m_req[2] === 1'b1 && n < 300) begin
            n++;
            tick();
        end
        n_checks++;
        if (n != 200) begin
            n_fail++;
            $display("FAIL timeout_len: req cycles=%0d, expected 200", n);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (ap_busy !== 1'b0 || ap_rdata !== e.rdata || ap_slverr !== e.slverr) begin
            n_fail++;
            $display("FAIL timeout_done: busy=%b rdata=%h slverr=%b, expected 0/%h/%b",
                     ap_busy, ap_rdata, ap_slverr, e.rdata, e.slverr);
        end
        ap_clrerr = 1'b1;
        tick();
        ap_clrerr = 1'b0;
        $display("timeout after %0d cycles", n);
    endtask

    task automatic test_abort();
        // Minimum transaction: ready in the first ACT cycle.
        issue(8'd3, 6'h1, 32'h0, 1'b1);
        exp_q.push_back('{rdata: 32'h1234_5678, slverr: 1'b0});
        m_ready = 4'b1000;
        m_rdata[32*3 +: 32] = 32'h1234_5678;
        n_checks++;
        if (ap_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL min_busy: busy=%b, expected 1", ap_busy);
        end
        tick();
        m_ready = '0;
        e = exp_q.pop_front();
        n_checks++;
        if (ap_busy !== 1'b0 || ap_rdata !== e.rdata || ap_slverr !== e.slverr) begin
            n_fail++;
            $display("FAIL min_done: busy=%b rdata=%h slverr=%b, expected 0/%h/%b",
                     ap_busy, ap_rdata, ap_slverr, e.rdata, e.slverr);
        end
        $display("min transaction rdata=%h", ap_rdata);

        // Abort and ready together: ready wins, no error.
        issue(8'd0, 6'h2, 32'hAAAA_AAAA, 1'b0);
        exp_q.push_back('{rdata: 32'h1234_5678, slverr: 1'b0});
        ap_abort = 1'b1;
        m_ready = 4'b0001;
        m_slverr = 4'b0000;
        tick();
        ap_abort = 1'b0;
        m_ready = '0;
        e = exp_q.pop_front();
        n_checks++;
        if (ap_busy !== 1'b0 || ap_rdata !== e.rdata || ap_slverr !== e.slverr) begin
            n_fail++;
            $display("FAIL abort_ready: busy=%b rdata=%h slverr=%b, expected 0/%h/%b",
                     ap_busy, ap_rdata, ap_slverr, e.rdata, e.slverr);
        end
        $display("abort+ready write slverr=%b", ap_slverr);

        // Abort alone on a read: error, read data untouched.
        issue(8'd0, 6'h2, 32'h0, 1'b1);
        exp_q.push_back('{rdata: 32'h1234_5678, slverr: 1'b1});
        tick();
        ap_abort = 1'b1;
        tick();
        ap_abort = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (ap_busy !== 1'b0 || m_req !== 4'b0 || ap_rdata !== e.rdata || ap_slverr !== e.slverr) begin
            n_fail++;
            $display("FAIL abort_only: busy=%b req=%b rdata=%h slverr=%b, expected 0/0000/%h/%b",
                     ap_busy, m_req, ap_rdata, ap_slverr, e.rdata, e.slverr);
        end
        $display("abort alone slverr=%b", ap_slverr);

        // AP error reported with a simultaneous clear: set wins, rdata forced to 0.
        issue(8'd0, 6'h4, 32'h0, 1'b1);
        exp_q.push_back('{rdata: 32'h0, slverr: 1'b1});
        m_ready = 4'b0001;
        m_slverr = 4'b0001;
        m_rdata[32*0 +: 32] = 32'hFFFF_FFFF;
        ap_clrerr = 1'b1;
        tick();
        m_ready = '0;
        m_slverr = '0;
        ap_clrerr = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (ap_rdata !== e.rdata || ap_slverr !== e.slverr) begin
            n_fail++;
            $display("FAIL set_beats_clr: rdata=%h slverr=%b, expected %h/%b",
                     ap_rdata, ap_slverr, e.rdata, e.slverr);
        end
        ap_clrerr = 1'b1;
        tick();
        ap_clrerr = 1'b0;
        $display("slave error with clear, slverr now %b", ap_slverr);
    endtask

    task automatic test_back_to_back();
        issue(8'd1, 6'h11, 32'hA5A5_A5A5, 1'b0);
        exp_q.push_back('{rdata: 32'h0, slverr: 1'b0});
        ap_upd = 1'b1; ap_sel = 8'd3; ap_addr = 6'h22; ap_wdata = 32'h5A5A_5A5A; ap_rnw = 1'b1;
        tick();
        ap_upd = 1'b0;
        n_checks++;
        if (m_addr !== 6'h11 || m_wdata !== 32'hA5A5_A5A5 || m_rnw !== 1'b0 || m_req !== 4'b0010) begin
            n_fail++;
            $display("FAIL busy_upd: addr=%h wdata=%h rnw=%b req=%b, expected 11/a5a5a5a5/0/0010",
                     m_addr, m_wdata, m_rnw, m_req);
        end
        m_ready = 4'b0010;
        tick();
        m_ready = '0;
        e = exp_q.pop_front();
        n_checks++;
        if (ap_busy !== 1'b0 || ap_rdata !== e.rdata || ap_slverr !== e.slverr) begin
            n_fail++;
            $display("FAIL b2b_first: busy=%b rdata=%h slverr=%b, expected 0/%h/%b",
                     ap_busy, ap_rdata, ap_slverr, e.rdata, e.slverr);
        end
        $display("first write done, second upd ignored");

        issue(8'd3, 6'h22, 32'h5A5A_5A5A, 1'b1);
        exp_q.push_back('{rdata: 32'h0BAD_BEEF, slverr: 1'b0});
        n_checks++;
        if (m_req !== 4'b1000 || m_addr !== 6'h22 || m_wdata !== 32'h5A5A_5A5A) begin
            n_fail++;
            $display("FAIL b2b_second: req=%b addr=%h wdata=%h, expected 1000/22/5a5a5a5a", m_req, m_addr, m_wdata);
        end
        m_ready = 4'b0001;
        m_rdata[32*0 +: 32] = 32'h1111_1111;
        tick();
        m_ready = '0;
        n_checks++;
        if (ap_busy !== 1'b1 || m_req !== 4'b1000) begin
            n_fail++;
            $display("FAIL wrong_ready: busy=%b req=%b, expected 1/1000", ap_busy, m_req);
        end
        m_ready = 4'b1000;
        m_rdata[32*3 +: 32] = 32'h0BAD_BEEF;
        tick();
        m_ready = '0;
        e = exp_q.pop_front();
        n_checks++;
        if (ap_busy !== 1'b0 || ap_rdata !== e.rdata || ap_slverr !== e.slverr) begin
            n_fail++;
            $display("FAIL b2b_read: busy=%b rdata=%h slverr=%b, expected 0/%h/%b",
                     ap_busy, ap_rdata, ap_slverr, e.rdata, e.slverr);
        end
        $display("second read sel=3 rdata=%h", ap_rdata);
    endtask

    task automatic test_trst();
        issue(8'd1, 6'h9, 32'h0, 1'b1);
        n_checks++;
        if (m_req !== 4'b0010) begin
            n_fail++;
            $display("FAIL trst_pre: req=%b, expected 0010", m_req);
        end
        #3;
        trst = 1'b1;
        #1;
        n_checks++;
        if (m_req !== 4'b0 || ap_busy !== 1'b0 || ap_rdata !== 32'h0 || ap_ack !== 3'h2) begin
            n_fail++;
            $display("FAIL trst_async: req=%b busy=%b rdata=%h ack=%h, expected 0000/0/0/2",
                     m_req, ap_busy, ap_rdata, ap_ack);
        end
        tick();
        trst = 1'b0;
        tick();
        $display("async reset mid-transaction");
    endtask

    initial begin
        test_reset();
        test_read();
        test_unmapped();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_trst();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: %0d left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
